// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S default geometry and slot/channel encoding
package i2s_pkg;
    localparam int I2S_WIDTH = 24;
    localparam int I2S_SLOT = 32;
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides mclk into the bit clock and flags each bit-clock falling edge
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic mclk,
    input  logic rst,
    output logic i2s_bclk,
    output logic fall
);
    localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] TOP = DW'(BCLK_DIV - 1);
    logic [DW-1:0] div_cnt;
    logic wrap;
    always_comb begin
        wrap = div_cnt == TOP;
        fall = wrap && i2s_bclk;
    end
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            i2s_bclk <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) i2s_bclk <= !i2s_bclk;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter with a one-pair holding buffer, driving bclk/wclk/dout from mclk
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH,
    parameter int SLOT = I2S_SLOT,
    parameter int BCLK_DIV = 4
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dataL,
    input  logic [WIDTH-1:0] dataR,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             i2s_bclk,
    output logic             i2s_wclk,
    output logic             dout,
    output logic             frame_start,
    output logic             underrun
);
    localparam int BW = $clog2(2 * SLOT);
    localparam logic [BW-1:0] LAST = BW'(2 * SLOT - 1);
    localparam logic [BW-1:0] SL = BW'(SLOT);
    localparam logic [BW-1:0] WD = BW'(WIDTH);
    logic fall, boundary, accept, buf_full, shift_en;
    logic [BW-1:0] bit_cnt, next_bit, slot_bit;
    logic [2*WIDTH-1:0] buf_q, shreg;
    chan_e chan;
    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .mclk(mclk),
        .rst(rst),
        .i2s_bclk(i2s_bclk),
        .fall(fall)
    );
    assign data_ready = !buf_full;
    always_comb begin
        boundary = fall && bit_cnt == LAST;
        accept = data_valid && !buf_full;
        next_bit = bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
        chan = next_bit >= SL ? CH_RIGHT : CH_LEFT;
        slot_bit = chan == CH_RIGHT ? next_bit - SL : next_bit;
        shift_en = slot_bit != '0 && slot_bit <= WD;
    end
    // {L,R} shifts out MSB-first: L during left data bits, then R during right data bits
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            bit_cnt <= LAST;
            i2s_wclk <= 1'b1;
            dout <= 1'b0;
            buf_full <= 1'b0;
            buf_q <= '0;
            shreg <= '0;
            frame_start <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (accept) begin
                buf_q <= {dataL, dataR};
                buf_full <= 1'b1;
            end else if (boundary) begin
                buf_full <= 1'b0;
            end
            frame_start <= boundary;
            underrun <= boundary && !buf_full;
            if (fall) begin
                bit_cnt <= next_bit;
                i2s_wclk <= chan == CH_RIGHT;
                dout <= shift_en && shreg[2*WIDTH-1];
                if (boundary) shreg <= buf_full ? buf_q : '0;
                else if (shift_en) shreg <= shreg << 1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized bench for i2s_tx at default geometry and at WIDTH=16/BCLK_DIV=1
module tb_i2s_tx;
    localparam int S = 32;
    logic mclk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] vld = '0;
    logic [1:0] rdy, bclk, wclk, dout, fs, und;
    logic [1:0][23:0] dl, dr;
    int n [2];
    bit pv [2], cu [2], acc [2];
    logic [23:0] pl [2], pr [2], cl [2], cr [2];
    int mode [2];
    int n_chk = 0;
    int n_pass = 0;
    always #5 mclk = ~mclk;
    i2s_tx dut0 (
        .mclk(mclk), .rst(rst), .dataL(dl[0]), .dataR(dr[0]), .data_valid(vld[0]),
        .data_ready(rdy[0]), .i2s_bclk(bclk[0]), .i2s_wclk(wclk[0]), .dout(dout[0]),
        .frame_start(fs[0]), .underrun(und[0])
    );
    i2s_tx #(.WIDTH(16), .SLOT(32), .BCLK_DIV(1)) dut1 (
        .mclk(mclk), .rst(rst), .dataL(dl[1][15:0]), .dataR(dr[1][15:0]), .data_valid(vld[1]),
        .data_ready(rdy[1]), .i2s_bclk(bclk[1]), .i2s_wclk(wclk[1]), .dout(dout[1]),
        .frame_start(fs[1]), .underrun(und[1])
    );
    function automatic int div_of(int u);
        return u != 0 ? 1 : 4;
    endfunction
    function automatic int wid_of(int u);
        return u != 0 ? 16 : 24;
    endfunction
    function automatic bit is_bnd(int u, int m);
        int d;
        d = div_of(u);
        return m >= 2 * d && (m - 2 * d) % (4 * S * d) == 0;
    endfunction
    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask
    task automatic model_reset(int u);
        n[u] = 0;
        pv[u] = 0;
        cu[u] = 0;
        acc[u] = 0;
        cl[u] = '0;
        cr[u] = '0;
    endtask
    task automatic model_edge(int u, logic v);
        bit a;
        a = v && !pv[u];
        n[u]++;
        acc[u] = a;
        if (is_bnd(u, n[u])) begin
            cu[u] = !pv[u];
            cl[u] = pv[u] ? pl[u] : '0;
            cr[u] = pv[u] ? pr[u] : '0;
            pv[u] = 0;
        end
        if (a) begin
            pv[u] = 1;
            pl[u] = dl[u];
            pr[u] = dr[u];
        end
    endtask
    task automatic compare(int u);
        int d, w, s, p, k, ew, ed;
        logic [23:0] smp;
        string t;
        d = div_of(u);
        w = wid_of(u);
        t = u != 0 ? "w16" : "w24";
        s = n[u] / (2 * d);
        ew = 1;
        ed = 0;
        if (s > 0) begin
            p = (s - 1) % (2 * S);
            k = p % S;
            ew = int'(p >= S);
            smp = p >= S ? cr[u] : cl[u];
            ed = (k >= 1 && k <= w) ? int'(smp[w-k]) : 0;
        end
        check($sformatf("%s bclk n=%0d", t, n[u]), int'(bclk[u]), (n[u] / d) % 2);
        check($sformatf("%s wclk n=%0d", t, n[u]), int'(wclk[u]), ew);
        check($sformatf("%s dout n=%0d", t, n[u]), int'(dout[u]), ed);
        check($sformatf("%s ready n=%0d", t, n[u]), int'(rdy[u]), int'(!pv[u]));
        check($sformatf("%s frame_start n=%0d", t, n[u]), int'(fs[u]), int'(is_bnd(u, n[u])));
        check($sformatf("%s underrun n=%0d", t, n[u]), int'(und[u]), int'(is_bnd(u, n[u]) && cu[u]));
    endtask
    task automatic drive(int u);
        if (mode[u] == 1 && acc[u]) mode[u] = 0;
        if (mode[u] == 0) begin
            vld[u] = 1'b0;
        end else if (mode[u] == 1) begin
            vld[u] = 1'b1;
        end else begin
            if (acc[u] || !vld[u]) begin
                dl[u] = 24'($urandom);
                dr[u] = 24'($urandom);
            end
            vld[u] = mode[u] == 2 ? 1'b1 : $urandom_range(0, 199) == 0;
        end
    endtask
    task automatic step();
        logic [1:0] v;
        v = vld;
        @(posedge mclk);
        if (!rst) for (int u = 0; u < 2; u++) model_edge(u, v[u]);
        @(negedge mclk);
        for (int u = 0; u < 2; u++) compare(u);
        for (int u = 0; u < 2; u++) drive(u);
    endtask
    initial begin
        int guard;
        dl[0] = 24'hA5C3F1;
        dr[0] = 24'h800001;
        dl[1] = 24'($urandom);
        dr[1] = 24'($urandom);
        mode[0] = 1;
        mode[1] = 3;
        for (int u = 0; u < 2; u++) model_reset(u);
        repeat (2) @(negedge mclk);
        compare(0);
        compare(1);
        rst = 1'b0;
        vld[0] = 1'b1;
        repeat (8) step();
        check("first_frame_start", int'(fs[0]), 1);
        check("first_underrun", int'(und[0]), 0);
        repeat (3 * 512) step();
        mode[0] = 2;
        repeat (4 * 512) step();
        mode[0] = 0;
        guard = 0;
        while (!(pv[0] == 0 && is_bnd(0, n[0] + 1)) && guard < 2000) begin
            step();
            guard++;
        end
        if (guard >= 2000) check("boundary_wait_timeout", guard, 0);
        dl[0] = 24'($urandom);
        dr[0] = 24'($urandom);
        vld[0] = 1'b1;
        mode[0] = 1;
        step();
        check("bnd_accept_underrun", int'(und[0]), 1);
        check("bnd_accept_ready", int'(rdy[0]), 0);
        repeat (520) step();
        mode[0] = 2;
        guard = 0;
        while (!(pv[0] && n[0] >= 8 && ((n[0] / 8 - 1) % 64) == 40) && guard < 2000) begin
            step();
            guard++;
        end
        if (guard >= 2000) check("right_slot_wait_timeout", guard, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_bclk", int'(bclk[0]), 0);
        check("rst_wclk", int'(wclk[0]), 1);
        check("rst_dout", int'(dout[0]), 0);
        check("rst_ready", int'(rdy[0]), 1);
        check("rst_frame_start", int'(fs[0]), 0);
        check("rst_underrun", int'(und[0]), 0);
        for (int u = 0; u < 2; u++) model_reset(u);
        compare(1);
        vld[0] = 1'b0;
        mode[0] = 0;
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;
        repeat (8) step();
        check("rst_first_frame_start", int'(fs[0]), 1);
        check("rst_first_underrun", int'(und[0]), 1);
        repeat (600) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S transmitter: serializes stereo PCM sample pairs onto a single data line and generates the matching bit clock and word clock from one master clock. It is the transmit-side counterpart of the I2S_Data receiver and of the I2S_Core clock generator. It feeds the audio DAC or loopback path from the same master clock domain. Sample pairs arrive over a valid/ready handshake into a one-entry holding buffer, so an upstream FIFO or DSP stage can run ahead by one frame.

## Interface
- WIDTH, 24: sample width in bits; must satisfy 1 <= WIDTH <= SLOT-1
- SLOT, 32: bit clocks per channel slot; a frame is 2*SLOT bit clocks
- BCLK_DIV, 4: mclk cycles per bit-clock half-period (>= 1); bit-clock period = 2*BCLK_DIV mclk cycles
- mclk  in  1  master clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- dataL  in  WIDTH  left sample, two's complement
- dataR  in  WIDTH  right sample, two's complement
- data_valid  in  1  dataL/dataR pair valid
- data_ready  out  1  holding buffer empty; a pair is accepted on any mclk edge with data_valid && data_ready
- i2s_bclk  out  1  bit clock
- i2s_wclk  out  1  word clock; 0 = left slot, 1 = right slot
- dout  out  1  serial data
- frame_start  out  1  one-mclk pulse at each frame boundary
- underrun  out  1  one-mclk pulse when a frame starts with the buffer empty

## Operation
- Prescaler div_cnt counts 0..BCLK_DIV-1 and wraps. i2s_bclk toggles on each wrap. A wrap with i2s_bclk currently 1 is a "fall strobe".
- Bit counter bit_cnt counts 0..2*SLOT-1 and advances only on a fall strobe. It wraps 2*SLOT-1 to 0, and that wrap is the frame boundary.
- On each fall strobe, i2s_wclk <= (new bit_cnt >= SLOT).
- Slot bit k (0..SLOT-1) of each channel is driven on dout as follows:
  - k = 0: 0 (I2S one-bit delay)
  - k = 1..WIDTH: sample[WIDTH-k], MSB first
  - k > WIDTH: 0 (pad)
- dout updates only on fall strobes.
- Holding buffer: a single {L,R} register plus a buf_full flag. data_ready = !buf_full.
- At the frame boundary:
  - If buf_full (the registered value before any same-cycle accept): copy the buffer into the shift register, clear buf_full, pulse frame_start.
  - Otherwise: load zeros into the shift register and pulse both frame_start and underrun.
- Accept and frame boundary in the same cycle: the accepted pair lands in the buffer and is used at the next frame. The current frame follows the empty-buffer rule (zeros, underrun pulse).
- Output signedness is preserved bit-exactly; there is no arithmetic on samples.
- Reset values: i2s_bclk 0, i2s_wclk 1, dout 0, data_ready 1, frame_start 0, underrun 0, div_cnt 0, bit_cnt 2*SLOT-1, buf_full 0, shift register 0.
- Reset asserted mid-frame returns all state to the reset values immediately. A pair held in the buffer is discarded.

## Timing
- After rst deasserts, the first fall strobe (frame boundary) occurs at mclk edge 2*BCLK_DIV. At that edge i2s_wclk goes 0.
- All outputs are registered and change only on mclk rising edges.
- i2s_bclk and i2s_wclk have a fixed phase relation: wclk and dout transition only on bclk falling edges. The receiver samples on bclk rising edges.
- Accept-to-air latency: a pair accepted before a frame boundary starts on dout at that boundary. Its left MSB appears one bit clock later (slot bit 1).
- frame_start and underrun are high for exactly the one mclk cycle containing the boundary fall strobe.
- Frame period = 2*SLOT*2*BCLK_DIV mclk cycles; 512 cycles at the defaults.

## Structure
- Package i2s_pkg holds the shared default constants I2S_WIDTH=24 and I2S_SLOT=32, and the slot/channel encoding (0 = left, 1 = right). I2S_Data uses the same package.
- Sub-module i2s_bclk_gen contains the prescaler, i2s_bclk and the fall-strobe output. The serializer, bit counter and buffer stay in i2s_tx.

## Test plan
- Single pair, defaults, dataL=24'hA5C3F1, dataR=24'h800001, presented before the first boundary:
  - frame_start at cycle 8, no underrun
  - sampled on bclk rises, dout gives L slot = 0, A5C3F1 MSB-first, then 7 zeros
  - R slot = 0, 800001, then 7 zeros
  - i2s_wclk is 0 for 32 bclks, then 1 for 32 bclks
- No data: every frame is all zeros, with underrun and frame_start pulsing every 512 cycles.
- Back-to-back stream (data_valid held 1):
  - data_ready falls after the accept and rises at each boundary
  - no underrun after the first frame
  - each pair is transmitted exactly once, in order
- Accept in the exact boundary cycle: that frame is zeros with an underrun pulse; the next frame carries the pair.
- rst pulsed mid-right-slot: outputs return to reset values asynchronously, the buffered pair is dropped, and the first frame_start comes 8 cycles after release.
- BCLK_DIV=1, WIDTH=16: bclk = mclk/2, frame = 128 cycles, 16 data bits plus 15 pad bits per slot.
